// File: rtl/qracc_pkg.sv
// Shared types and constants for the qracc feature-load path.
package qracc_pkg;

    localparam int unsigned QRACC_INPUT_WIDTH   = 256;
    localparam int unsigned QRACC_ELEMENT_WIDTH = 8;
    // Elements carried by one SRAM beat / loader write.
    localparam int unsigned FL_EPB = QRACC_INPUT_WIDTH / QRACC_ELEMENT_WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StLast,
        StDone
    } fetch_state_t;

endpackage

// File: rtl/feature_fetch_ctrl.sv
// Streams one activation vector from SRAM into the feature loader regfile,
// then publishes the valid element window and pulses done.
module feature_fetch_ctrl
    import qracc_pkg::*;
#(
    parameter int unsigned inputWidth   = QRACC_INPUT_WIDTH,
    parameter int unsigned addrWidth    = 8,
    parameter int unsigned elementWidth = QRACC_ELEMENT_WIDTH,
    parameter int unsigned numElements  = 128,
    parameter int unsigned memAddrWidth = 16
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    start_i,
    input  logic [memAddrWidth-1:0] base_addr_i,
    input  logic [15:0]             num_elems_i,
    output logic                    mem_rd_en_o,
    output logic [memAddrWidth-1:0] mem_addr_o,
    input  logic                    mem_gnt_i,
    input  logic [inputWidth-1:0]   mem_rdata_i,
    input  logic                    mem_rvalid_i,
    output logic                    fl_wr_en_o,
    output logic [addrWidth-1:0]    fl_addr_o,
    output logic [inputWidth-1:0]   fl_data_o,
    output logic [15:0]             mask_start_o,
    output logic [15:0]             mask_end_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int unsigned Epb = inputWidth / elementWidth;

    fetch_state_t            state_q, state_d;
    logic [memAddrWidth-1:0] base_q, base_d;
    logic [15:0]             n_q, n_d;
    logic [15:0]             req_cnt_q, req_cnt_d;
    logic [15:0]             rsp_cnt_q, rsp_cnt_d;
    logic                    fl_wr_en_q, fl_wr_en_d;
    logic [addrWidth-1:0]    fl_addr_q, fl_addr_d;
    logic [inputWidth-1:0]   fl_data_q, fl_data_d;
    logic [15:0]             mask_end_q, mask_end_d;
    logic                    done_q, done_d;
    logic [15:0]             n_clamped;
    logic [15:0]             beats;

    assign n_clamped = (num_elems_i > 16'(numElements)) ? 16'(numElements) : num_elems_i;
    assign beats     = 16'((32'(n_q) + Epb - 1) / Epb);

    assign mem_rd_en_o  = (state_q == StFetch) && (req_cnt_q < beats);
    assign mem_addr_o   = base_q + memAddrWidth'(req_cnt_q);
    assign fl_wr_en_o   = fl_wr_en_q;
    assign fl_addr_o    = fl_addr_q;
    assign fl_data_o    = fl_data_q;
    assign mask_start_o = 16'd0;
    assign mask_end_o   = mask_end_q;
    assign busy_o       = (state_q != StIdle);
    assign done_o       = done_q;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        n_d        = n_q;
        req_cnt_d  = req_cnt_q;
        rsp_cnt_d  = rsp_cnt_q;
        fl_wr_en_d = 1'b0;
        fl_addr_d  = fl_addr_q;
        fl_data_d  = fl_data_q;
        mask_end_d = mask_end_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    base_d     = base_addr_i;
                    n_d        = n_clamped;
                    req_cnt_d  = '0;
                    rsp_cnt_d  = '0;
                    mask_end_d = '0;
                    state_d    = (n_clamped == '0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                if (mem_rd_en_o && mem_gnt_i) begin
                    req_cnt_d = req_cnt_q + 16'd1;
                end
                if (mem_rvalid_i) begin
                    fl_wr_en_d = 1'b1;
                    fl_addr_d  = addrWidth'(32'(rsp_cnt_q) * Epb);
                    fl_data_d  = mem_rdata_i;
                    rsp_cnt_d  = rsp_cnt_q + 16'd1;
                    if (rsp_cnt_d == beats) begin
                        state_d = StLast;
                    end
                end
            end
            StLast:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // The mask only opens once the final loader write has landed.
        if (state_d == StDone) begin
            done_d     = 1'b1;
            mask_end_d = n_d;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= StIdle;
            base_q     <= '0;
            n_q        <= '0;
            req_cnt_q  <= '0;
            rsp_cnt_q  <= '0;
            fl_wr_en_q <= 1'b0;
            fl_addr_q  <= '0;
            fl_data_q  <= '0;
            mask_end_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            n_q        <= n_d;
            req_cnt_q  <= req_cnt_d;
            rsp_cnt_q  <= rsp_cnt_d;
            fl_wr_en_q <= fl_wr_en_d;
            fl_addr_q  <= fl_addr_d;
            fl_data_q  <= fl_data_d;
            mask_end_q <= mask_end_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_feature_fetch_ctrl.sv
// Scoreboard bench for feature_fetch_ctrl: SRAM model with configurable grant and
// latency, expected loader writes and completions queued at start, monitor pops.
module tb_feature_fetch_ctrl;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         start = 1'b0;
    logic [15:0]  base_addr = '0;
    logic [15:0]  num_elems = '0;
    logic         mem_rd_en;
    logic [15:0]  mem_addr;
    logic         mem_gnt = 1'b0;
    logic [255:0] mem_rdata = '0;
    logic         mem_rvalid = 1'b0;
    logic         fl_wr_en;
    logic [7:0]   fl_addr;
    logic [255:0] fl_data;
    logic [15:0]  mask_start;
    logic [15:0]  mask_end;
    logic         busy;
    logic         done;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    typedef struct { logic [7:0] addr; logic [255:0] data; } wr_t;
    typedef struct { int n; int beats; int start_cyc; bit fixed; } ld_t;
    typedef struct { int due; logic [15:0] a; } rq_t;

    wr_t exp_wr[$];
    ld_t exp_ld[$];
    rq_t pend[$];

    int gnt_mode = 0;    // 0 always, 1 every other cycle, 2 random
    int lat_mode = 0;    // 0 one cycle, 1 plus three, 2 random extra
    bit stray = 1'b0;
    int acc_cnt = 0;
    int last_rv_cyc = 0;
    int done_cnt = 0;

    feature_fetch_ctrl dut (
        .clk          (clk),
        .nrst         (nrst),
        .start_i      (start),
        .base_addr_i  (base_addr),
        .num_elems_i  (num_elems),
        .mem_rd_en_o  (mem_rd_en),
        .mem_addr_o   (mem_addr),
        .mem_gnt_i    (mem_gnt),
        .mem_rdata_i  (mem_rdata),
        .mem_rvalid_i (mem_rvalid),
        .fl_wr_en_o   (fl_wr_en),
        .fl_addr_o    (fl_addr),
        .fl_data_o    (fl_data),
        .mask_start_o (mask_start),
        .mask_end_o   (mask_end),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [255:0] word_data(input logic [15:0] a);
        logic [255:0] d;
        for (int k = 0; k < 16; k++) d[k*16 +: 16] = a ^ 16'(k * 40503);
        return d;
    endfunction

    // SRAM: in-order responses, each at least one cycle after acceptance.
    always @(negedge clk) begin
        rq_t r;
        int due;
        if (!nrst) begin
            pend.delete();
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata = {8{$urandom()}};
            if (stray) begin
                mem_rvalid = 1'b1;
            end else if (pend.size() > 0 && pend[0].due == cyc) begin
                r = pend.pop_front();
                mem_rvalid = 1'b1;
                mem_rdata = word_data(r.a);
                last_rv_cyc = cyc;
            end
            case (gnt_mode)
                0: mem_gnt = 1'b1;
                1: mem_gnt = (cyc % 2 == 0);
                default: mem_gnt = 1'($urandom_range(0, 1));
            endcase
            if (mem_rd_en && mem_gnt) begin
                due = cyc + 1 + ((lat_mode == 0) ? 0 : (lat_mode == 1) ? 3 : $urandom_range(0, 3));
                if (pend.size() > 0 && due <= pend[$].due) due = pend[$].due + 1;
                pend.push_back('{due: due, a: mem_addr});
                acc_cnt++;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        wr_t w;
        ld_t ld;
        if (nrst) begin
            if (fl_wr_en) begin
                chk("write_expected", 256'(exp_wr.size() > 0), 1);
                if (exp_wr.size() > 0) begin
                    w = exp_wr.pop_front();
                    chk("fl_addr", fl_addr, w.addr);
                    chk("fl_data", fl_data, w.data);
                end
            end
            if (done) begin
                chk("done_expected", 256'(exp_ld.size() > 0), 1);
                if (exp_ld.size() > 0) begin
                    ld = exp_ld.pop_front();
                    chk("mask_end", mask_end, ld.n);
                    chk("mask_start", mask_start, 0);
                    chk("reads_issued", acc_cnt, ld.beats);
                    chk("writes_outstanding", exp_wr.size(), 0);
                    if (ld.n == 0) chk("done_latency_n0", cyc, ld.start_cyc + 1);
                    else chk("done_after_last_rvalid", cyc, last_rv_cyc + 2);
                    if (ld.fixed && ld.n > 0)
                        chk("done_cycle_nostall", cyc, ld.start_cyc + ld.beats + 3);
                end
                done_cnt++;
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_fl_wr_en", fl_wr_en, 0);
        chk("rst_fl_addr", fl_addr, 0);
        chk("rst_fl_data", fl_data, 0);
        chk("rst_mask_start", mask_start, 0);
        chk("rst_mask_end", mask_end, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
    endtask

    task automatic push_expect(input logic [15:0] b, input logic [15:0] num, input bit fixed);
        int n;
        int beats;
        n = (num > 16'd128) ? 128 : int'(num);
        beats = (n + 31) / 32;
        for (int i = 0; i < beats; i++)
            exp_wr.push_back('{addr: 8'(i * 32), data: word_data(b + 16'(i))});
        exp_ld.push_back('{n: n, beats: beats, start_cyc: cyc, fixed: fixed});
    endtask

    task automatic run_load(input logic [15:0] b, input logic [15:0] num, input bit fixed,
                            input int dup);
        int target;
        @(negedge clk);
        chk("idle_before_start", busy, 0);
        target = done_cnt + 1;
        push_expect(b, num, fixed);
        acc_cnt = 0;
        start = 1'b1;
        base_addr = b;
        num_elems = num;
        @(negedge clk);
        start = 1'b0;
        base_addr = 16'($urandom());
        num_elems = 16'($urandom());
        chk("busy_after_start", busy, 1);
        if (dup > 0) begin
            repeat (dup) @(negedge clk);
            start = 1'b1;
            base_addr = 16'h3000;
            num_elems = 16'd100;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 400 && done_cnt < target; i++) @(posedge clk);
        chk("done_within_budget", 256'(done_cnt >= target), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (actual=timeout required=finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_reset_outputs();
        @(negedge clk);
        nrst = 1'b1;

        gnt_mode = 0; lat_mode = 0;
        run_load(16'h0100, 16'd128, 1'b1, 0);
        run_load(16'h0200, 16'd40, 1'b1, 0);
        run_load(16'h0300, 16'd0, 1'b1, 0);
        run_load(16'h0400, 16'd200, 1'b1, 0);

        gnt_mode = 1; lat_mode = 1;
        run_load(16'h0500, 16'd128, 1'b0, 0);

        gnt_mode = 0; lat_mode = 0;
        run_load(16'h0600, 16'd64, 1'b1, 2);

        @(negedge clk);
        stray = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("stray_no_write", fl_wr_en, 0);
            chk("stray_idle", busy, 0);
        end
        stray = 1'b0;
        @(negedge clk);
        chk("stray_no_write_tail", fl_wr_en, 0);

        run_load(16'hFFFE, 16'd100, 1'b1, 0);

        // Reset in the middle of a load.
        @(negedge clk);
        push_expect(16'h0700, 16'd128, 1'b0);
        start = 1'b1; base_addr = 16'h0700; num_elems = 16'd128;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b0;
        #1;
        check_reset_outputs();
        exp_wr.delete();
        exp_ld.delete();
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_rd_en", mem_rd_en, 0);
            chk("rst_hold_wr_en", fl_wr_en, 0);
        end
        nrst = 1'b1;
        run_load(16'h0800, 16'd32, 1'b1, 0);

        for (int r = 0; r < 20; r++) begin
            logic [15:0] num;
            gnt_mode = $urandom_range(0, 2);
            lat_mode = $urandom_range(0, 2);
            num = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(129, 400))
                                              : 16'($urandom_range(0, 128));
            run_load(16'($urandom()), num, (gnt_mode == 0 && lat_mode == 0), 0);
        end

        repeat (5) @(negedge clk);
        chk("leftover_writes", exp_wr.size(), 0);
        chk("leftover_loads", exp_ld.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
